// File: rtl/seq_divider_core.sv
// Iterative unsigned restoring divider: 2N-bit dividend / N-bit divisor -> N-bit quotient and remainder.
// One quotient bit per clock. Divide-by-zero and quotient overflow finish immediately with saturated outputs.
module seq_divider_core #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] A,
    input  logic [N-1:0]   B,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   Q,
    output logic [N-1:0]   R,
    output logic           ovf,
    output logic           dbz
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t        r_state, w_state_next;
    logic [N-1:0]  r_rem, w_rem_next;
    logic [N-1:0]  r_quo, w_quo_next;
    logic [N-1:0]  r_div, w_div_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic [N-1:0]  r_q, w_q_next;
    logic [N-1:0]  r_r, w_r_next;
    logic          r_ovf, w_ovf_next;
    logic          r_dbz, w_dbz_next;

    // The remainder is always below the divisor, so its (N+1)th bit is only
    // ever non-zero transiently in the shifted value and is not stored.
    logic [N:0]    w_shift;
    logic          w_ge;
    logic [N-1:0]  w_trial;
    logic [N-1:0]  w_quo_shift;
    logic          w_last;

    assign w_shift     = {r_rem, r_quo[N-1]};
    assign w_ge        = (w_shift >= {1'b0, r_div});
    assign w_trial     = w_shift[N-1:0] - r_div;
    assign w_quo_shift = {r_quo[N-2:0], w_ge};
    assign w_last      = (r_cnt == CW'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_cnt   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_ovf   <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_rem   <= w_rem_next;
            r_quo   <= w_quo_next;
            r_div   <= w_div_next;
            r_cnt   <= w_cnt_next;
            r_q     <= w_q_next;
            r_r     <= w_r_next;
            r_ovf   <= w_ovf_next;
            r_dbz   <= w_dbz_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_rem_next   = r_rem;
        w_quo_next   = r_quo;
        w_div_next   = r_div;
        w_cnt_next   = r_cnt;
        w_q_next     = r_q;
        w_r_next     = r_r;
        w_ovf_next   = r_ovf;
        w_dbz_next   = r_dbz;
        unique case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_div_next = B;
                    w_cnt_next = '0;
                    if (B == '0) begin
                        w_state_next = S_DONE;
                        w_dbz_next   = 1'b1;
                        w_ovf_next   = 1'b0;
                        w_q_next     = '1;
                        w_r_next     = '0;
                    end else if (A[2*N-1:N] >= B) begin
                        w_state_next = S_DONE;
                        w_ovf_next   = 1'b1;
                        w_dbz_next   = 1'b0;
                        w_q_next     = '1;
                        w_r_next     = '0;
                    end else begin
                        w_state_next = S_CALC;
                        w_rem_next   = A[2*N-1:N];
                        w_quo_next   = A[N-1:0];
                        w_ovf_next   = 1'b0;
                        w_dbz_next   = 1'b0;
                    end
                end
            end
            S_CALC: begin
                w_rem_next = w_ge ? w_trial : w_shift[N-1:0];
                w_quo_next = w_quo_shift;
                w_cnt_next = r_cnt + CW'(1);
                if (w_last) begin
                    w_state_next = S_DONE;
                    w_cnt_next   = '0;
                    w_q_next     = w_quo_shift;
                    w_r_next     = w_ge ? w_trial : w_shift[N-1:0];
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign Q         = r_q;
    assign R         = r_r;
    assign ovf       = r_ovf;
    assign dbz       = r_dbz;
endmodule

// File: tb/tb_seq_divider_core.sv
// Directed bench for seq_divider_core (N=8): results, flags, latency, backpressure and reset abort.
module tb_seq_divider_core;
    localparam int N = 8;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [2*N-1:0] A;
    logic [N-1:0]   B;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   Q;
    logic [N-1:0]   R;
    logic           ovf;
    logic           dbz;

    int n_cmp;
    int n_err;

    seq_divider_core #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q         (Q),
        .R         (R),
        .ovf       (ovf),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // One transaction: accept, wait for result, optionally stall with noise on the input side, then drain.
    task automatic do_div(input string tag, input logic [15:0] a_v, input logic [7:0] b_v,
                          input logic [7:0] eq, input logic [7:0] er,
                          input logic eovf, input logic edbz, input int elat,
                          input int stall, input bit noisy);
        int lat;
        logic [7:0] q0, r0;
        @(negedge clk);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        A = a_v;
        B = b_v;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = noisy;
        if (noisy) begin
            A = 16'hDEAD;
            B = 8'h00;
        end
        lat = 0;
        while (!out_valid && lat < 40) begin
            check({tag, ".busy_in_ready"}, 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(elat));
        check({tag, ".Q"}, 32'(Q), 32'(eq));
        check({tag, ".R"}, 32'(R), 32'(er));
        check({tag, ".ovf"}, 32'(ovf), 32'(eovf));
        check({tag, ".dbz"}, 32'(dbz), 32'(edbz));
        q0 = Q;
        r0 = R;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            check({tag, ".stall_valid"}, 32'(out_valid), 32'd1);
            check({tag, ".stall_ready"}, 32'(in_ready), 32'd0);
            check({tag, ".stall_QR"}, {16'h0, Q, R}, {16'h0, q0, r0});
            check({tag, ".stall_flags"}, {30'h0, ovf, dbz}, {30'h0, eovf, edbz});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, ".drain_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".drain_ready"}, 32'(in_ready), 32'd1);
        $display("txn %s: A=0x%04h B=0x%02h -> Q=0x%02h R=0x%02h ovf=%0d dbz=%0d lat=%0d",
                 tag, a_v, b_v, q0, r0, eovf, edbz, lat);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.in_ready", 32'(in_ready), 32'd1);
        check("reset.QR", {16'h0, Q, R}, 32'd0);
        check("reset.flags", {30'h0, ovf, dbz}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 12345 / 123 = 100 r 45
        do_div("basic",   16'h3039, 8'h7B, 8'h64, 8'h2D, 1'b0, 1'b0, N, 0, 1'b0);
        // 65279 / 255 = 255 r 254
        do_div("maxq",    16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b0, 1'b0, N, 0, 1'b0);
        do_div("ovf",     16'h8000, 8'h10, 8'hFF, 8'h00, 1'b1, 1'b0, 0, 0, 1'b0);
        do_div("dbz",     16'h1234, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b1, 0, 0, 1'b0);
        // high half equal to divisor is the first overflowing value; one below is 255 r 9
        do_div("ovf_edge",16'h0A00, 8'h0A, 8'hFF, 8'h00, 1'b1, 1'b0, 0, 0, 1'b0);
        do_div("max_edge",16'h09FF, 8'h0A, 8'hFF, 8'h09, 1'b0, 1'b0, N, 0, 1'b0);
        // 10283 = 171*60 + 23, with operand noise during CALC and a 5-cycle stall
        do_div("stall",   16'h282B, 8'h3C, 8'hAB, 8'h17, 1'b0, 1'b0, N, 5, 1'b1);
        // back-to-back after release: 18199 = 90*200 + 199
        do_div("stream1", 16'h4717, 8'hC8, 8'h5A, 8'hC7, 1'b0, 1'b0, N, 0, 1'b0);
        do_div("stream2", 16'h00FF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, N, 0, 1'b0);
        do_div("stream3", 16'h00FE, 8'hFF, 8'h00, 8'hFE, 1'b0, 1'b0, N, 0, 1'b0);
        do_div("zero",    16'h0000, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0, N, 0, 1'b0);

        // Reset in the middle of an operation.
        @(negedge clk);
        A = 16'h3039;
        B = 8'h7B;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort.busy", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("abort.out_valid", 32'(out_valid), 32'd0);
        check("abort.in_ready", 32'(in_ready), 32'd1);
        check("abort.QR", {16'h0, Q, R}, 32'd0);
        check("abort.flags", {30'h0, ovf, dbz}, 32'd0);
        $display("txn abort: reset asserted after 4 iterations");
        @(negedge clk);
        rst = 1'b0;
        do_div("after_rst", 16'h0064, 8'h0A, 8'h0A, 8'h00, 1'b0, 1'b0, N, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
